// File: rtl/univ_shift_reg.sv
// Universal shift register: hold, parallel load, logical shifts, rotates,
// arithmetic shift right and increment, plus terminal-count and change flags.
module univ_shift_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin_l,
  input  logic             sin_r,
  output logic [WIDTH-1:0] q,
  output logic             sout_msb,
  output logic             sout_lsb,
  output logic             tc,
  output logic             chg
);

  typedef enum logic [2:0] {
    OP_HOLD = 3'b000,
    OP_LOAD = 3'b001,
    OP_SHL  = 3'b010,
    OP_SHR  = 3'b011,
    OP_ROL  = 3'b100,
    OP_ROR  = 3'b101,
    OP_ASR  = 3'b110,
    OP_INC  = 3'b111
  } op_e;

  op_e op;
  assign op = op_e'(mode);

  logic [WIDTH-1:0] q_q, q_d;
  logic             chg_q, chg_d;

  always_comb begin
    q_d = q_q;
    if (en) begin
      case (op)
        OP_HOLD: q_d = q_q;
        OP_LOAD: q_d = d;
        OP_SHL:  q_d = {q_q[WIDTH-2:0], sin_r};
        OP_SHR:  q_d = {sin_l, q_q[WIDTH-1:1]};
        OP_ROL:  q_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
        OP_ROR:  q_d = {q_q[0], q_q[WIDTH-1:1]};
        OP_ASR:  q_d = {q_q[WIDTH-1], q_q[WIDTH-1:1]};
        OP_INC:  q_d = q_q + {{(WIDTH-1){1'b0}}, 1'b1};
        default: q_d = q_q;
      endcase
    end
    // Flag only real changes, so no-op results (e.g. ROL of zero) stay quiet
    chg_d = (q_d != q_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q   <= '0;
      chg_q <= 1'b0;
    end else begin
      q_q   <= q_d;
      chg_q <= chg_d;
    end
  end

  assign q        = q_q;
  assign sout_msb = q_q[WIDTH-1];
  assign sout_lsb = q_q[0];
  assign chg      = chg_q;
  assign tc       = en & ~rst & (op == OP_INC) & (&q_q);

endmodule

// File: doc/univ_shift_reg.md
UNIV_SHIFT_REG -- requirements
Module: univ_shift_reg

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, register width in bits; legal range 2..64.
REQ-002 The block SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-003 The block SHALL have port rst  input  1  reset; synchronous and active-high.
REQ-004 The block SHALL have port en  input  1  operation enable; low = hold regardless of mode.
REQ-005 The block SHALL have port mode  input  3  operation select (encoding in REQ-010).
REQ-006 The block SHALL have port d  input  WIDTH  parallel load data.
REQ-007 The block SHALL have ports sin_l and sin_r  input  1 each  serial-in at MSB end and LSB end.
REQ-008 The block SHALL have ports q (output, WIDTH, register contents) and sout_msb/sout_lsb (output, 1 each, = q[WIDTH-1] and q[0], combinational from q).
REQ-009 The block SHALL have ports tc (output, 1, terminal count) and chg (output, 1, registered change pulse).

Function
REQ-010 Per rising edge with en=1 and rst=0, q SHALL update by mode:
 - 000 HOLD: q unchanged.
 - 001 LOAD: q <= d.
 - 010 SHL: q <= {q[WIDTH-2:0], sin_r}.
 - 011 SHR: q <= {sin_l, q[WIDTH-1:1]}.
 - 100 ROL: q <= {q[WIDTH-2:0], q[WIDTH-1]}.
 - 101 ROR: q <= {q[0], q[WIDTH-1:1]}.
 - 110 ASR: q <= {q[WIDTH-1], q[WIDTH-1:1]}; sign bit preserved, sin_l ignored.
 - 111 INC: q <= q + 1, modulo 2^WIDTH; all-ones wraps to zero.
REQ-011 With en=0, q SHALL hold for all modes; d, sin_l, sin_r are ignored.
REQ-012 Latency SHALL be one cycle: the result of an operation is visible on q after the rising edge that samples it.
REQ-013 tc SHALL be combinational: tc=1 iff en=1, mode=111, rst=0 and q is all ones; otherwise 0.
REQ-014 chg SHALL be registered: chg=1 for exactly the cycle after an edge where q's new value differs from its old value; 0 otherwise, including HOLD, en=0, and operations yielding the same value (e.g. ROL of all-zeros, LOAD of equal data).
REQ-015 Serial inputs SHALL only be consumed in SHL (sin_r) and SHR (sin_l).
REQ-016 Mode and en changes SHALL take effect on the very next edge; no pipeline or mode-transition delay.
REQ-017 All arithmetic SHALL be unsigned WIDTH-bit except ASR, which treats q[WIDTH-1] as sign.

Reset
REQ-018 With rst=1 at a rising edge, q SHALL become all zeros and chg SHALL become 0, overriding en and mode.
REQ-019 Reset asserted mid-sequence (any mode, en=1) SHALL discard the pending operation; first operation after release acts on q=0.
REQ-020 chg SHALL be 0 in the cycle following reset even when q was non-zero before reset.
REQ-021 Outputs before the first reset edge are undefined; bench SHALL apply reset for at least one edge first.

Verification
REQ-022 WIDTH=8: reset, LOAD d=8'hA5, then SHL with sin_r=1 -> q=8'hA5 then 8'h4B; chg=1 after each edge.
REQ-023 WIDTH=8: LOAD 8'h81, ROR x2 then ROL x2 -> q=8'hC0, 8'h60, 8'hC0, 8'h81; sout_lsb tracks q[0].
REQ-024 WIDTH=8: LOAD 8'h90, ASR x3 -> q=8'hC8, 8'hE4, 8'hF2; SHR with sin_l=0 from 8'h90 -> 8'h48.
REQ-025 WIDTH=4: LOAD 4'hE, INC x2 -> q=4'hF with tc=1 during that cycle, then 4'h0 (wrap) with tc=0.
REQ-026 WIDTH=8: LOAD 8'h3C, en=0 with mode=SHL for 3 cycles -> q stays 8'h3C, chg=0; then rst=1 with en=1, mode=INC -> q=8'h00, chg=0.
REQ-027 Each scenario SHALL be rerun at WIDTH=2 and WIDTH=32 with equivalent stimulus scaled to width, checking wrap and sign behaviour at both extremes.
